// File: rtl/fetch_unit.sv
// Instruction fetch stage: strobes pc/mem to read a 1-3 byte instruction off data_bus
// and presents it to the control unit over a valid/ready handshake (no prefetch).
module fetch_unit #(
  parameter int unsigned MEM_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  data_bus,
  output logic        pc_r,
  output logic        pc_inc,
  output logic        mem_ce,
  output logic        mem_r,
  output logic        mem_oe,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [7:0]  opcode,
  output logic [15:0] operand,
  output logic [1:0]  instr_len,
  input  logic        flush,
  output logic        busy
);

  typedef enum logic [1:0] {ADDR, WAIT, DATA, HOLD} state_t;

  localparam logic [1:0] WAIT_LAST = (MEM_LAT > 1) ? 2'(MEM_LAT - 2) : '0;

  state_t     state;
  logic [1:0] byte_idx;
  logic [1:0] wait_cnt;
  logic [1:0] len_now;
  logic       last_byte;
  logic       active;

  function automatic logic [1:0] decode_len(input logic [1:0] hi);
    case (hi)
      2'b00:   decode_len = 2'd1;
      2'b01:   decode_len = 2'd2;
      default: decode_len = 2'd3;
    endcase
  endfunction

  // Length is only known once byte 0 is on the bus, so decode it live for that byte.
  always_comb begin
    len_now   = (byte_idx == 2'd0) ? decode_len(data_bus[7:6]) : instr_len;
    last_byte = (byte_idx == len_now - 2'd1);
  end

  // Reset gates strobes directly so nothing leaks onto the bus while rst is held.
  always_comb begin
    active = !rst && (state != HOLD);
    pc_r   = active;
    mem_ce = active;
    mem_oe = active;
    busy   = active;
    mem_r  = !rst && !flush && (state == ADDR);
    pc_inc = !rst && !flush && (state == DATA);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ADDR;
      byte_idx    <= '0;
      wait_cnt    <= '0;
      opcode      <= '0;
      operand     <= '0;
      instr_len   <= '0;
      instr_valid <= 1'b0;
    end else if (flush) begin
      state       <= ADDR;
      byte_idx    <= '0;
      wait_cnt    <= '0;
      operand     <= '0;
      instr_valid <= 1'b0;
    end else begin
      case (state)
        ADDR: begin
          wait_cnt <= '0;
          state    <= (MEM_LAT > 1) ? WAIT : DATA;
        end
        WAIT: begin
          if (wait_cnt == WAIT_LAST) state <= DATA;
          else                       wait_cnt <= wait_cnt + 2'd1;
        end
        DATA: begin
          case (byte_idx)
            2'd0: begin
              opcode    <= data_bus;
              instr_len <= len_now;
            end
            2'd1:    operand[7:0]  <= data_bus;
            default: operand[15:8] <= data_bus;
          endcase
          if (last_byte) begin
            state       <= HOLD;
            instr_valid <= 1'b1;
          end else begin
            state    <= ADDR;
            byte_idx <= (byte_idx == 2'd2) ? 2'd2 : byte_idx + 2'd1;
          end
        end
        HOLD: begin
          if (instr_ready) begin
            state       <= ADDR;
            instr_valid <= 1'b0;
            operand     <= '0;
            byte_idx    <= '0;
          end
        end
        default: state <= ADDR;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed instruction table, flush/reset/latency corner cases,
// and random memory images checked against an instruction-stream model.
module tb_fetch_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst1, rst3, ready, flush, sel;
  logic [7:0]  mem [256];
  logic [7:0]  pc1, pc3, flush_pc;
  logic [7:0]  bus1, bus3;

  logic        pc_r1, pc_inc1, mem_ce1, mem_r1, mem_oe1, valid1, busy1;
  logic [7:0]  op1;
  logic [15:0] opd1;
  logic [1:0]  len1;
  logic        pc_r3, pc_inc3, mem_ce3, mem_r3, mem_oe3, valid3, busy3;
  logic [7:0]  op3;
  logic [15:0] opd3;
  logic [1:0]  len3;

  assign bus1 = mem[pc1];
  assign bus3 = mem[pc3];

  fetch_unit #(.MEM_LAT(1)) dut1 (
    .clk(clk), .rst(rst1), .data_bus(bus1), .pc_r(pc_r1), .pc_inc(pc_inc1),
    .mem_ce(mem_ce1), .mem_r(mem_r1), .mem_oe(mem_oe1), .instr_valid(valid1),
    .instr_ready(ready), .opcode(op1), .operand(opd1), .instr_len(len1),
    .flush(flush), .busy(busy1)
  );

  fetch_unit #(.MEM_LAT(3)) dut3 (
    .clk(clk), .rst(rst3), .data_bus(bus3), .pc_r(pc_r3), .pc_inc(pc_inc3),
    .mem_ce(mem_ce3), .mem_r(mem_r3), .mem_oe(mem_oe3), .instr_valid(valid3),
    .instr_ready(ready), .opcode(op3), .operand(opd3), .instr_len(len3),
    .flush(flush), .busy(busy3)
  );

  // External program counter owned by the bench
  always @(posedge clk) begin
    if (rst1)         pc1 <= '0;
    else if (flush)   pc1 <= flush_pc;
    else if (pc_inc1) pc1 <= pc1 + 8'd1;
    if (rst3)         pc3 <= '0;
    else if (flush)   pc3 <= flush_pc;
    else if (pc_inc3) pc3 <= pc3 + 8'd1;
  end

  // strobes: [4] pc_r, [3] pc_inc, [2] mem_ce, [1] mem_r, [0] mem_oe
  logic [4:0]  cur_strb;
  logic        cur_valid, cur_busy;
  logic [7:0]  cur_op;
  logic [15:0] cur_opd;
  logic [1:0]  cur_len;
  assign cur_strb  = sel ? {pc_r3, pc_inc3, mem_ce3, mem_r3, mem_oe3}
                         : {pc_r1, pc_inc1, mem_ce1, mem_r1, mem_oe1};
  assign cur_valid = sel ? valid3 : valid1;
  assign cur_busy  = sel ? busy3  : busy1;
  assign cur_op    = sel ? op3    : op1;
  assign cur_opd   = sel ? opd3   : opd1;
  assign cur_len   = sel ? len3   : len1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h", name, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " rst strobes"}, 32'(cur_strb), 0);
    check({tag, " rst valid"},   32'(cur_valid), 0);
    check({tag, " rst busy"},    32'(cur_busy), 0);
    check({tag, " rst opcode"},  32'(cur_op), 0);
    check({tag, " rst operand"}, 32'(cur_opd), 0);
    check({tag, " rst len"},     32'(cur_len), 0);
  endtask

  // Entered in the first (ADDR) cycle of a fetch; leaves in the first cycle of the next one.
  task automatic fetch_check(input string tag, input int hold, input logic [7:0] eop,
                             input logic [15:0] eopd, input logic [1:0] elen, input int elat);
    int lat = 0;
    int incs = 0;
    logic [7:0]  op;
    logic [15:0] opd;
    logic [1:0]  len;
    while (cur_valid !== 1'b1 && lat < 60) begin
      incs += int'(cur_strb[3]);
      lat++;
      step();
    end
    check({tag, " latency"}, 32'(lat), 32'(elat));
    check({tag, " pc_inc count"}, 32'(incs), 32'(elen));
    op = cur_op; opd = cur_opd; len = cur_len;
    check({tag, " opcode"},  32'(op),  32'(eop));
    check({tag, " operand"}, 32'(opd), 32'(eopd));
    check({tag, " len"},     32'(len), 32'(elen));
    for (int i = 0; i < hold; i++) begin
      step();
      check({tag, " hold strobes"}, 32'(cur_strb), 0);
      check({tag, " hold busy"},    32'(cur_busy), 0);
      check({tag, " hold valid"},   32'(cur_valid), 1);
      check({tag, " hold stable"},  {cur_op, cur_opd, 6'd0, cur_len}, {op, opd, 6'd0, len});
    end
    ready = 1'b1;
    step();
    ready = 1'b0;
    #1;
    check({tag, " accept valid"}, 32'(cur_valid), 0);
    check({tag, " accept addr"},  32'({cur_busy, cur_strb[1]}), 32'h3);
  endtask

  typedef struct {
    logic [7:0]  b0, b1, b2;
    logic [1:0]  len;
    logic [15:0] opd;
    int          lat;
    int          hold;
  } vec_t;

  vec_t vecs [8];

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0]  ref_pc, rop;
    logic [15:0] ropd;
    logic [1:0]  rlen;
    int          p;

    vecs[0] = '{8'h00, 8'h00, 8'h00, 2'd1, 16'h0000, 2, 1};
    vecs[1] = '{8'hff, 8'h00, 8'hff, 2'd3, 16'hff00, 6, 0};
    vecs[2] = '{8'h40, 8'h5a, 8'h00, 2'd2, 16'h005a, 4, 5};
    vecs[3] = '{8'h80, 8'h12, 8'h34, 2'd3, 16'h3412, 6, 2};
    vecs[4] = '{8'h3f, 8'h00, 8'h00, 2'd1, 16'h0000, 2, 0};
    vecs[5] = '{8'h7f, 8'ha5, 8'h00, 2'd2, 16'h00a5, 4, 1};
    vecs[6] = '{8'hc3, 8'h01, 8'h80, 2'd3, 16'h8001, 6, 0};
    vecs[7] = '{8'hbf, 8'hff, 8'hff, 2'd3, 16'hffff, 6, 3};

    rst1 = 1'b1; rst3 = 1'b1; ready = 1'b0; flush = 1'b0; sel = 1'b0; flush_pc = '0;
    for (int i = 0; i < 256; i++) mem[i] = 8'hee;
    p = 0;
    for (int i = 0; i < 8; i++) begin
      mem[p] = vecs[i].b0;
      if (vecs[i].len > 1) mem[p + 1] = vecs[i].b1;
      if (vecs[i].len > 2) mem[p + 2] = vecs[i].b2;
      p += int'(vecs[i].len);
    end
    mem[p] = 8'hff; mem[p + 1] = 8'h11; mem[p + 2] = 8'h22;
    mem[8'h80] = 8'h41; mem[8'h81] = 8'h33;

    step(); step();
    check_reset_outputs("ml1");
    rst1 = 1'b0;
    #1;
    for (int i = 0; i < 8; i++)
      fetch_check($sformatf("row%0d", i), vecs[i].hold, vecs[i].b0, vecs[i].opd,
                  vecs[i].len, vecs[i].lat);

    // Flush during DATA of byte 1 of a 3-byte instruction
    step(); step(); step();
    check("flush pre pc_inc", 32'(cur_strb[3]), 1);
    flush_pc = 8'h80;
    flush = 1'b1;
    #1;
    check("flush pc_inc suppressed", 32'(cur_strb[3]), 0);
    check("flush valid", 32'(cur_valid), 0);
    step();
    flush = 1'b0;
    #1;
    check("flush refetch addr", 32'({cur_busy, cur_strb[1], cur_valid}), 32'h6);
    fetch_check("after flush", 1, 8'h41, 16'h0033, 2'd2, 4);

    // MEM_LAT=3 instance, including reset in WAIT of the second byte
    rst1 = 1'b1;
    sel = 1'b1;
    mem[0] = 8'h40; mem[1] = 8'h5a;
    step(); step();
    check_reset_outputs("ml3");
    rst3 = 1'b0;
    #1;
    repeat (5) step();
    check("ml3 in wait", 32'({cur_busy, cur_strb}), 32'h35);
    rst3 = 1'b1;
    step();
    check_reset_outputs("ml3 mid-wait");
    rst3 = 1'b0;
    #1;
    fetch_check("ml3 instr", 2, 8'h40, 16'h005a, 2'd2, 8);

    // Random memory image against the instruction-stream model
    rst3 = 1'b1;
    rst1 = 1'b1;
    sel = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    step(); step();
    rst1 = 1'b0;
    #1;
    ref_pc = '0;
    for (int n = 0; n < 60; n++) begin
      rop  = mem[ref_pc];
      rlen = (rop < 8'h40) ? 2'd1 : (rop < 8'h80) ? 2'd2 : 2'd3;
      ropd = '0;
      if (rlen >= 2'd2) ropd[7:0]  = mem[8'(ref_pc + 8'd1)];
      if (rlen == 2'd3) ropd[15:8] = mem[8'(ref_pc + 8'd2)];
      fetch_check($sformatf("rand%0d", n), int'($urandom_range(3, 0)), rop, ropd, rlen,
                  2 * int'(rlen));
      ref_pc = ref_pc + 8'(rlen);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
